// File: rtl/uart_io_master.sv
// uart_io_master
// Host-side initiator for the j1a peripheral IO bus. A byte command stream
// arrives from the buart receiver. Each command issues one io_rd or io_wr
// cycle, or none, and the reply bytes go out through the buart transmitter.
//   'W' AH AL DH DL -> io_wr, reply 0x2B
//   'R' AH AL       -> io_rd, reply DH DL
//   'P'             -> reply 0x50
//   other           -> reply 0x3F
// Ports:
//   clk, resetq              clock, async active-low reset
//   rx_valid, rx_data, rx_rd buart receive side (rx_rd = 1-clk consume pulse)
//   tx_busy, tx_wr, tx_data  buart transmit side (tx_wr = 1-clk send pulse)
//   io_rd, io_wr             1-clk IO strobes, never high together
//   io_addr, io_dout, io_din IO address / write data / read data
//   busy                     high in any state other than IDLE
module uart_io_master #(
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 12000,
  parameter int TO_W    = 14
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_rd,
  input  logic        tx_busy,
  output logic        tx_wr,
  output logic [7:0]  tx_data,
  output logic        io_rd,
  output logic        io_wr,
  output logic [15:0] io_addr,
  output logic [15:0] io_dout,
  input  logic [15:0] io_din,
  output logic        busy
);

  localparam logic [7:0] OP_W  = 8'h57;
  localparam logic [7:0] OP_R  = 8'h52;
  localparam logic [7:0] OP_P  = 8'h50;
  localparam logic [7:0] R_ACK = 8'h2B;
  localparam logic [7:0] R_BAD = 8'h3F;

  typedef enum logic [2:0] {IDLE, ARGS, BUS, RDWAIT, RESP} state_t;

  state_t          state, state_nx;
  logic            take;
  logic            rx_hold, tx_hold;  // one-clk holdoff after each rx_rd / tx_wr
  logic            is_wr;
  logic [2:0]      argc;
  logic [23:0]     shreg;
  logic [31:0]     sh_nx;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic [7:0]      lat_cnt;
  logic [1:0]      resp_cnt;
  logic [7:0]      resp_lo;

  assign sh_nx  = {shreg, rx_data};
  assign to_hit = (to_cnt == TO_W'(TIMEOUT));
  assign rx_rd  = take;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    tx_wr    = 1'b0;
    io_rd    = 1'b0;
    io_wr    = 1'b0;
    case (state)
      IDLE: if (rx_valid && !rx_hold) begin
        take     = 1'b1;
        state_nx = (rx_data == OP_W || rx_data == OP_R) ? ARGS : RESP;
      end
      ARGS: begin
        if (rx_valid && !rx_hold) begin
          take = 1'b1;
          if (argc == 3'd1) state_nx = BUS;
        end else if (to_hit) begin
          state_nx = IDLE;  // abandon the partial command silently
        end
      end
      BUS: begin
        io_wr    = is_wr;
        io_rd    = !is_wr;
        state_nx = is_wr ? RESP : RDWAIT;
      end
      RDWAIT: if (lat_cnt == 8'd0) state_nx = RESP;
      RESP: if (!tx_busy && !tx_hold) begin
        tx_wr = 1'b1;
        if (resp_cnt == 2'd1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_hold  <= 1'b0;
      tx_hold  <= 1'b0;
      is_wr    <= 1'b0;
      argc     <= '0;
      shreg    <= '0;
      to_cnt   <= '0;
      lat_cnt  <= '0;
      resp_cnt <= '0;
      resp_lo  <= '0;
      io_addr  <= '0;
      io_dout  <= '0;
      tx_data  <= '0;
    end else begin
      rx_hold <= take;
      tx_hold <= tx_wr;
      case (state)
        IDLE: if (take) begin
          is_wr  <= (rx_data == OP_W);
          argc   <= (rx_data == OP_W) ? 3'd4 : 3'd2;
          to_cnt <= '0;
          if (rx_data != OP_W && rx_data != OP_R) begin
            tx_data  <= (rx_data == OP_P) ? OP_P : R_BAD;
            resp_cnt <= 2'd1;
          end
        end
        ARGS: begin
          if (take) begin
            shreg  <= sh_nx[23:0];
            argc   <= argc - 3'd1;
            to_cnt <= '0;
            if (argc == 3'd1) begin
              // last argument byte: latch the bus fields straight from sh_nx
              if (is_wr) {io_addr, io_dout} <= sh_nx;
              else       io_addr <= sh_nx[15:0];
            end
          end else if (!to_hit) begin
            to_cnt <= to_cnt + 1'b1;  // saturates at TIMEOUT
          end
        end
        BUS: begin
          lat_cnt <= 8'(RD_LAT - 1);
          if (is_wr) begin
            tx_data  <= R_ACK;
            resp_cnt <= 2'd1;
          end
        end
        RDWAIT: begin
          if (lat_cnt == 8'd0) begin
            tx_data  <= io_din[15:8];
            resp_lo  <= io_din[7:0];
            resp_cnt <= 2'd2;
          end else begin
            lat_cnt <= lat_cnt - 8'd1;
          end
        end
        RESP: if (tx_wr) begin
          resp_cnt <= resp_cnt - 2'd1;
          if (resp_cnt == 2'd2) tx_data <= resp_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_io_master.sv
// Testbench for uart_io_master: table-driven command vectors plus directed
// sequences for reset mid-command, timeout and back-to-back stalled traffic.
// The buart model keeps rx_valid high one clk after rx_rd and raises
// tx_busy one clk after tx_wr, mirroring the real buart lag.
module tb_uart_io_master;
  localparam int TO = 12000;

  logic        clk, resetq;
  logic        rx_valid, rx_rd, tx_busy, tx_wr, io_rd, io_wr, busy;
  logic [7:0]  rx_data, tx_data;
  logic [15:0] io_addr, io_dout, io_din;

  uart_io_master #(.RD_LAT(1), .TIMEOUT(TO), .TO_W(14)) dut (
    .clk(clk), .resetq(resetq), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_rd(rx_rd), .tx_busy(tx_busy), .tx_wr(tx_wr), .tx_data(tx_data),
    .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr), .io_dout(io_dout),
    .io_din(io_din), .busy(busy)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  int n_cmp = 0, n_bad = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_log[$];
  logic [15:0] rd_log[$];
  int n_wr, n_rd, n_consec, n_both, stall;
  logic [15:0] last_addr, last_dout;

  function automatic logic [15:0] io_map(input logic [15:0] a);
    case (a)
      16'h2000: return 16'h0003;
      16'hFFFF: return 16'hBEEF;
      16'h0000: return 16'h1234;
      default:  return 16'hC0DE;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #2;
  endtask

  task automatic clr_logs();
    tx_log.delete(); rd_log.delete();
    n_wr = 0; n_rd = 0;
  endtask

  // buart + IO decode model: sample DUT at negedge, update inputs at posedge+1
  initial begin : model
    logic rd_now, wr_now, iord_now, stale, tx_pend;
    logic [7:0] stale_b;
    logic [15:0] rd_a;
    int tx_cnt;
    bit prev_rd;
    rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0; io_din = 16'hDEAD;
    n_consec = 0; n_both = 0; stall = 0; tx_cnt = 0; tx_pend = 1'b0;
    prev_rd = 1'b0; stale = 1'b0; stale_b = 8'h00; rd_a = 16'h0;
    forever begin
      @(negedge clk);
      rd_now = rx_rd; wr_now = tx_wr; iord_now = io_rd; rd_a = io_addr;
      if (rx_rd && prev_rd) n_consec++;
      prev_rd = rx_rd;
      if (io_rd && io_wr) n_both++;
      if (io_wr) begin n_wr++; last_addr = io_addr; last_dout = io_dout; end
      if (io_rd) begin n_rd++; last_addr = io_addr; rd_log.push_back(io_addr); end
      if (tx_wr) tx_log.push_back(tx_data);
      @(posedge clk); #1;
      if (rd_now && rx_q.size() > 0) begin stale_b = rx_q.pop_front(); stale = 1'b1; end
      else stale = 1'b0;
      if (stale)                 begin rx_valid = 1'b1; rx_data = stale_b; end
      else if (rx_q.size() > 0)  begin rx_valid = 1'b1; rx_data = rx_q[0]; end
      else                       rx_valid = 1'b0;
      if (stall > 0) stall--;
      if (tx_cnt > 0) tx_cnt--;
      if (tx_pend) tx_cnt = 3;
      tx_pend = wr_now;
      tx_busy = (stall > 0) || (tx_cnt > 0);
      io_din  = iord_now ? io_map(rd_a) : 16'hDEAD;
    end
  end

  task automatic push(input logic [47:0] c, input int n);
    for (int i = 0; i < n; i++) rx_q.push_back(c[47-8*i -: 8]);
  endtask

  task automatic wait_done(input string name, input int ntx);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (tx_log.size() >= ntx && !busy && rx_q.size() == 0 && !rx_valid) begin
        ok = 1'b1; break;
      end
    end
    repeat (8) tick();  // catch any stray extra byte or strobe
    chk({name, " done"}, 32'(ok), 32'd1);
  endtask

  task automatic chk_tx(input string name, input int ntx, input logic [31:0] exp);
    chk({name, " ntx"}, 32'(tx_log.size()), 32'(ntx));
    for (int i = 0; i < ntx; i++)
      chk($sformatf("%s tx%0d", name, i),
          (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hFFFF_FFFF, 32'(exp[31-8*i -: 8]));
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [47:0] cmd;
    int          nwr, nrd;
    logic [15:0] addr, dout;
    int          ntx;
    logic [31:0] tx;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{"wr4",    5, 48'h57_00_04_00_15_00, 1, 0, 16'h0004, 16'h0015, 1, 32'h2B00_0000};
    vt[1] = '{"rd2000", 3, 48'h52_20_00_00_00_00, 0, 1, 16'h2000, 16'h0000, 2, 32'h0003_0000};
    vt[2] = '{"illA5",  1, 48'hA5_00_00_00_00_00, 0, 0, 16'h0000, 16'h0000, 1, 32'h3F00_0000};
    vt[3] = '{"ping",   1, 48'h50_00_00_00_00_00, 0, 0, 16'h0000, 16'h0000, 1, 32'h5000_0000};
    vt[4] = '{"wrFFFF", 5, 48'h57_FF_FF_A5_5A_00, 1, 0, 16'hFFFF, 16'hA55A, 1, 32'h2B00_0000};
    vt[5] = '{"ill72",  1, 48'h72_00_00_00_00_00, 0, 0, 16'h0000, 16'h0000, 1, 32'h3F00_0000};
    vt[6] = '{"rd0000", 3, 48'h52_00_00_00_00_00, 0, 1, 16'h0000, 16'h0000, 2, 32'h1234_0000};

    resetq = 1'b0;
    clr_logs();
    repeat (3) tick();
    chk("reset outs", {rx_rd, tx_wr, io_rd, io_wr, busy, 8'h00, tx_data, 8'h00}, 32'h0);
    chk("reset bus", {io_addr, io_dout}, 32'h0);
    resetq = 1'b1;
    repeat (2) tick();

    // table-driven commands
    for (int v = 0; v < 7; v++) begin
      clr_logs();
      push(vt[v].cmd, vt[v].n);
      wait_done(vt[v].name, vt[v].ntx);
      chk({vt[v].name, " nwr"}, 32'(n_wr), 32'(vt[v].nwr));
      chk({vt[v].name, " nrd"}, 32'(n_rd), 32'(vt[v].nrd));
      if (vt[v].nwr + vt[v].nrd > 0) chk({vt[v].name, " addr"}, 32'(last_addr), 32'(vt[v].addr));
      if (vt[v].nwr > 0)             chk({vt[v].name, " dout"}, 32'(last_dout), 32'(vt[v].dout));
      chk_tx(vt[v].name, vt[v].ntx, vt[v].tx);
    end

    // reset in the middle of ARGS, with nonzero io_addr/tx_data left behind
    clr_logs();
    push(48'h57_12_00_00_00_00, 2);
    for (int i = 0; i < 50 && (rx_q.size() > 0 || rx_valid); i++) tick();
    repeat (3) tick();
    chk("midargs busy", 32'(busy), 32'd1);
    resetq = 1'b0;
    #1;
    chk("rst mid outs", {rx_rd, tx_wr, io_rd, io_wr, busy, 8'h00, tx_data, 8'h00}, 32'h0);
    chk("rst mid bus", {io_addr, io_dout}, 32'h0);
    repeat (2) tick();
    resetq = 1'b1;
    tick();
    clr_logs();
    push(48'h50_00_00_00_00_00, 1);
    wait_done("post-reset ping", 1);
    chk("post-reset strobes", 32'(n_wr + n_rd), 32'd0);
    chk_tx("post-reset ping", 1, 32'h5000_0000);

    // timeout: exactly TIMEOUT+1 idle clks after the last taken byte
    clr_logs();
    push(48'h57_12_00_00_00_00, 2);
    for (int i = 0; i < 50 && rx_q.size() > 0; i++) tick();
    repeat (TO) tick();
    chk("timeout not early", 32'(busy), 32'd1);
    tick();
    chk("timeout busy", 32'(busy), 32'd0);
    repeat (4) tick();
    chk("timeout strobes", 32'(n_wr + n_rd), 32'd0);
    chk("timeout ntx", 32'(tx_log.size()), 32'd0);
    push(48'h50_00_00_00_00_00, 1);
    wait_done("timeout ping", 1);
    chk_tx("timeout ping", 1, 32'h5000_0000);

    // back-to-back reads with a stalled transmitter
    clr_logs();
    n_consec = 0;
    stall = 100;
    push(48'h52_FF_FF_52_00_00, 6);
    wait_done("b2b", 4);
    chk("b2b consec rx_rd", 32'(n_consec), 32'd0);
    chk("b2b nrd", 32'(n_rd), 32'd2);
    chk("b2b nwr", 32'(n_wr), 32'd0);
    chk("b2b addr0", (rd_log.size() > 0) ? 32'(rd_log[0]) : 32'hFFFF_FFFF, 32'h0000_FFFF);
    chk("b2b addr1", (rd_log.size() > 1) ? 32'(rd_log[1]) : 32'hFFFF_FFFF, 32'h0000_0000);
    chk_tx("b2b", 4, 32'hBEEF_1234);

    chk("rd/wr overlap", 32'(n_both), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end
endmodule
